// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// master: the fetch/decode side driving the queue; slave: the queue itself.
interface fetch_queue_if #(
  parameter int MACHINE_WIDTH = 2,
  parameter int DATA_W        = 64
);
  logic [MACHINE_WIDTH-1:0]        in_valid;
  logic [MACHINE_WIDTH*DATA_W-1:0] in_data;
  logic                            in_ready;
  logic                            out_ready;
  logic [MACHINE_WIDTH-1:0]        out_valid;
  logic [MACHINE_WIDTH*DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and the decode pipeline register.
// Up to MACHINE_WIDTH entries pushed and popped per cycle, strict FIFO order,
// no bypass: a pushed entry is visible to decode the following cycle.
// A flush from the hazard unit empties the queue and masks the outputs.
module fetch_queue #(
  parameter int MACHINE_WIDTH = 2,
  parameter int DEPTH         = 8,
  parameter int DATA_W        = 64,
  localparam int PTR_W        = $clog2(DEPTH),
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  fetch_queue_if.slave     bus,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MW_C    = CNT_W'(MACHINE_WIDTH);

  // Number of set bits; in_valid is contiguous so this is the push width.
  function automatic logic [CNT_W-1:0] popcount(input logic [MACHINE_WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = {CNT_W{1'b0}};
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  logic [DATA_W-1:0] storage_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              in_ready_s;
  logic              push_en_s;
  logic [CNT_W-1:0]  push_n_s;
  logic [CNT_W-1:0]  pop_n_s;
  logic [PTR_W-1:0]  wr_idx_s [MACHINE_WIDTH];
  logic [PTR_W-1:0]  rd_idx_s [MACHINE_WIDTH];
  logic [MACHINE_WIDTH-1:0]        out_valid_s;
  logic [MACHINE_WIDTH*DATA_W-1:0] out_data_s;

  // Push/pop amounts and next pointer/occupancy; flush overrides both.
  always_comb begin
    in_ready_s = (DEPTH_C - count_q) >= MW_C;
    push_en_s  = in_ready_s & ~flush;
    if (push_en_s) begin
      push_n_s = popcount(bus.in_valid);
    end else begin
      push_n_s = {CNT_W{1'b0}};
    end
    if (bus.out_ready & ~flush) begin
      pop_n_s = (count_q < MW_C) ? count_q : MW_C;
    end else begin
      pop_n_s = {CNT_W{1'b0}};
    end
    if (flush) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      // DEPTH is a power of two, so truncation is the modulo wrap.
      head_d  = head_q + PTR_W'(pop_n_s);
      tail_d  = tail_q + PTR_W'(push_n_s);
      count_d = count_q + push_n_s - pop_n_s;
    end
  end

  // Per-slot write/read addresses and the decode-facing view of the head.
  always_comb begin
    out_valid_s = {MACHINE_WIDTH{1'b0}};
    out_data_s  = {(MACHINE_WIDTH*DATA_W){1'b0}};
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      wr_idx_s[i] = tail_q + PTR_W'(i);
      rd_idx_s[i] = head_q + PTR_W'(i);
      out_valid_s[i] = (CNT_W'(i) < count_q) & ~flush;
      out_data_s[i*DATA_W +: DATA_W] = storage_q[rd_idx_s[i]];
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care out of reset, so no reset here.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      if (push_en_s && bus.in_valid[i]) begin
        storage_q[wr_idx_s[i]] <= bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_s;
  assign count         = count_q;

  fetch_queue_chk #(
    .MACHINE_WIDTH (MACHINE_WIDTH),
    .DEPTH         (DEPTH)
  ) u_chk (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (bus.in_valid),
    .count    (count_q)
  );

endmodule

// Protocol checks for the fetch queue.
module fetch_queue_chk #(
  parameter int MACHINE_WIDTH = 2,
  parameter int DEPTH         = 8,
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input logic                     clk,
  input logic                     resetn,
  input logic [MACHINE_WIDTH-1:0] in_valid,
  input logic [CNT_W-1:0]         count
);
  localparam logic [MACHINE_WIDTH-1:0] ONE_C   = MACHINE_WIDTH'(1);
  localparam logic [CNT_W-1:0]         DEPTH_C = CNT_W'(DEPTH);

  // in_valid must be a run of ones starting at slot 0.
  a_in_valid_contig: assert property (@(posedge clk) disable iff (!resetn)
    ((in_valid & (in_valid + ONE_C)) == {MACHINE_WIDTH{1'b0}}));

  // Occupancy never exceeds capacity.
  a_count_range: assert property (@(posedge clk) disable iff (!resetn)
    (count <= DEPTH_C));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, basic/partial push, full + wrap,
// flush and near-full simultaneous push/pop.
module tb_fetch_queue;
  localparam int MW    = 2;
  localparam int DW    = 64;
  localparam int DEPTH = 8;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic       flush  = 1'b0;
  logic [3:0] count;

  fetch_queue_if #(.MACHINE_WIDTH(MW), .DATA_W(DW)) bus ();

  fetch_queue #(.MACHINE_WIDTH(MW), .DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus),
    .count  (count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q [$];
  int          mc       = 0;
  logic [31:0] nxt_pc   = 32'h0;

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, pc ^ 32'h1357_9BDF};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // One clock: drive inputs, check outputs against the expected queue, advance.
  task automatic cycle(input logic [1:0] iv, input logic ordy, input logic fl);
    logic [1:0] ev;
    int npush;
    int npop;
    bus.in_valid  = iv;
    bus.in_data   = {ent(nxt_pc + 32'd4), ent(nxt_pc)};
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(mc <= DEPTH - MW));
    chk("count", 64'(count), 64'(mc));
    ev = fl ? 2'b00 : (mc >= 2 ? 2'b11 : (mc == 1 ? 2'b01 : 2'b00));
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    if (ev[0]) chk("slot0", bus.out_data[63:0], ent(exp_q[0]));
    if (ev[1]) chk("slot1", bus.out_data[127:64], ent(exp_q[1]));
    if (fl) begin
      exp_q.delete();
      mc = 0;
    end else begin
      npop  = ordy ? ((mc < 2) ? mc : 2) : 0;
      npush = 0;
      if (mc <= DEPTH - MW) begin
        npush = iv[1] ? 2 : (iv[0] ? 1 : 0);
        for (int i = 0; i < npush; i++) exp_q.push_back(nxt_pc + 32'(4 * i));
        nxt_pc = nxt_pc + 32'(4 * npush);
      end
      for (int i = 0; i < npop; i++) void'(exp_q.pop_front());
      mc = mc + npush - npop;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 2'b00;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    chk("rst_count", 64'(count), 64'h0);
    #5 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Basic: two entries, held, then popped together.
    cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b00, 1'b0, 1'b0);
    chk("t2_pc1", 64'(bus.out_data[127:96]), 64'h4);
    cycle(2'b00, 1'b1, 1'b0);
    chk("t2_empty", 64'(count), 64'h0);

    // Partial: 0x8 alone, then 0xC/0x10; drain 0x8,0xC | 0x10.
    cycle(2'b01, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b00, 1'b1, 1'b0);
    chk("t3_last_pc", 64'(bus.out_data[63:32]), 64'h10);
    chk("t3_last_valid", 64'(bus.out_valid), 64'h1);
    cycle(2'b00, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b0);

    // Reset mid-traffic, then a push must still work.
    cycle(2'b11, 1'b0, 1'b0);
    bus.in_valid = 2'b11;
    resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'h1);
    chk("mid_rst_count", 64'(count), 64'h0);
    exp_q.delete();
    mc = 0;
    bus.in_valid = 2'b00;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b00, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b0);

    // Full, ignored fifth push, then 12 cycles of push+pop across wrap.
    for (int k = 0; k < 4; k++) cycle(2'b11, 1'b0, 1'b0);
    chk("t4_full_count", 64'(count), 64'h8);
    chk("t4_full_ready", 64'(bus.in_ready), 64'h0);
    cycle(2'b11, 1'b0, 1'b0);
    chk("t4_still_full", 64'(count), 64'h8);
    for (int k = 0; k < 12; k++) cycle(2'b11, 1'b1, 1'b0);
    for (int k = 0; k < 6 && mc > 0; k++) cycle(2'b00, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b0);

    // Flush at count=5 with push and pop requested.
    cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b01, 1'b0, 1'b0);
    chk("t5_pre_count", 64'(count), 64'h5);
    cycle(2'b11, 1'b1, 1'b1);
    chk("t5_post_count", 64'(count), 64'h0);
    nxt_pc = 32'hBFC0_0380;
    cycle(2'b01, 1'b0, 1'b0);
    chk("t5_alone_valid", 64'(bus.out_valid), 64'h1);
    chk("t5_alone_pc", 64'(bus.out_data[63:32]), 64'hBFC0_0380);
    cycle(2'b00, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b0);

    // Near-full: count=6 push2+pop2 holds; count=7 blocks push despite pop.
    for (int k = 0; k < 3; k++) cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b11, 1'b1, 1'b0);
    chk("t6_hold_count", 64'(count), 64'h6);
    chk("t6_hold_ready", 64'(bus.in_ready), 64'h1);
    cycle(2'b01, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    chk("t6_seven_ready", 64'(bus.in_ready), 64'h0);
    cycle(2'b11, 1'b1, 1'b0);
    chk("t6_after_count", 64'(count), 64'h5);
    for (int k = 0; k < 6 && mc > 0; k++) cycle(2'b00, 1'b1, 1'b0);
    cycle(2'b00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
